cu_core: RTL and testbench

Single-cycle control unit for the monocycle RV32I processor. It holds the program counter, decodes the current instruction into datapath control signals and immediates, resolves branches and jumps, and updates the PC once per clock. It sits between instruction memory (fetch address out, instruction in) and the register-file/ALU/data-memory datapath.

---
 rtl/cu_core.sv | 233 +++++++++++++++++++++++
 tb/tb_cu_core.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_core.sv
// Single-cycle RV32I control unit: holds the PC, decodes instr into datapath controls and immediates, and resolves branches and jumps.
// Latency: decode outputs are combinational in the same cycle; the PC advances on every rising clk_i edge.
// Backpressure: none; one instruction retires per cycle. An illegal instruction falls through to pc+4 with all enables low.
module cu_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [31:0] instr_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] imm_o,
    output logic        reg_write_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        alu_src_a_o,
    output logic        alu_src_b_o,
    output logic [3:0]  alu_ctrl_o,
    output logic [1:0]  wb_sel_o,
    output logic        illegal_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    logic [31:0] pc_q, pc_d;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i_fmt, imm_s_fmt, imm_b_fmt, imm_u_fmt, imm_j_fmt;
    logic        br_eq, br_lt, br_ltu, br_taken;

    // Decoded controls before reset gating of the enables
    logic        dec_reg_write, dec_mem_read, dec_mem_write;
    logic        dec_src_a, dec_src_b, dec_illegal;
    logic        is_branch, is_jal, is_jalr;
    logic [3:0]  dec_alu;
    logic [1:0]  dec_wb;
    logic [31:0] dec_imm;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    assign imm_i_fmt = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s_fmt = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b_fmt = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u_fmt = {instr_i[31:12], 12'b0};
    assign imm_j_fmt = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    // funct3 -> ALU op shared by R-type and I-ALU; alt selects SUB/SRA
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_of = ALU_SLL;
            3'b010:  alu_of = ALU_SLT;
            3'b011:  alu_of = ALU_SLTU;
            3'b100:  alu_of = ALU_XOR;
            3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_of = ALU_OR;
            default: alu_of = ALU_AND;
        endcase
    endfunction

    // Branch comparator: equality, signed and unsigned less-than of the register operands
    always_comb begin
        br_eq  = (rs1_data_i == rs2_data_i);
        br_lt  = ($signed(rs1_data_i) < $signed(rs2_data_i));
        br_ltu = (rs1_data_i < rs2_data_i);
        case (funct3)
            3'b000:  br_taken = br_eq;
            3'b001:  br_taken = !br_eq;
            3'b100:  br_taken = br_lt;
            3'b101:  br_taken = !br_lt;
            3'b110:  br_taken = br_ltu;
            3'b111:  br_taken = !br_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    // Instruction class decode; an illegal encoding leaves every control at zero
    always_comb begin
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_src_a     = 1'b0;
        dec_src_b     = 1'b0;
        dec_alu       = ALU_ADD;
        dec_wb        = WB_ALU;
        dec_imm       = 32'h0;
        dec_illegal   = 1'b0;
        is_branch     = 1'b0;
        is_jal        = 1'b0;
        is_jalr       = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    dec_reg_write = 1'b1;
                    dec_alu       = alu_of(funct3, funct7[5]);
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_I: begin
                if ((funct3 == 3'b001 && funct7 != 7'h00) ||
                    (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20)) begin
                    dec_illegal = 1'b1;
                end else begin
                    dec_reg_write = 1'b1;
                    dec_src_b     = 1'b1;
                    dec_alu       = alu_of(funct3, funct3 == 3'b101 && funct7[5]);
                    dec_imm       = imm_i_fmt;
                end
            end
            OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    dec_reg_write = 1'b1;
                    dec_mem_read  = 1'b1;
                    dec_src_b     = 1'b1;
                    dec_wb        = WB_MEM;
                    dec_imm       = imm_i_fmt;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_STORE: begin
                if (funct3 == 3'b010) begin
                    dec_mem_write = 1'b1;
                    dec_src_b     = 1'b1;
                    dec_imm       = imm_s_fmt;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    dec_illegal = 1'b1;
                end else begin
                    is_branch = 1'b1;
                    dec_alu   = ALU_SUB;
                    dec_imm   = imm_b_fmt;
                end
            end
            OP_JAL: begin
                is_jal        = 1'b1;
                dec_reg_write = 1'b1;
                dec_wb        = WB_PC4;
                dec_imm       = imm_j_fmt;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    is_jalr       = 1'b1;
                    dec_reg_write = 1'b1;
                    dec_wb        = WB_PC4;
                    dec_imm       = imm_i_fmt;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_LUI: begin
                dec_reg_write = 1'b1;
                dec_src_b     = 1'b1;
                dec_alu       = ALU_PASSB;
                dec_imm       = imm_u_fmt;
            end
            OP_AUIPC: begin
                dec_reg_write = 1'b1;
                dec_src_a     = 1'b1;
                dec_src_b     = 1'b1;
                dec_imm       = imm_u_fmt;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Next-PC select: taken branch / JAL are pc-relative, JALR is register-relative with bit 0 cleared
    always_comb begin
        pc_d = pc_plus4_o;
        if (is_jal || (is_branch && br_taken)) begin
            pc_d = pc_q + dec_imm;
        end else if (is_jalr) begin
            pc_d = (rs1_data_i + dec_imm) & ~32'h1;
        end
    end

    // PC register; reset reloads RESET_PC immediately and holds it while low
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o        = pc_q;
    assign pc_plus4_o  = pc_q + 32'd4;
    assign imm_o       = dec_imm;
    // Enables are suppressed while reset is low so an aborted instruction leaves no side effects
    assign reg_write_o = dec_reg_write & reset_ni;
    assign mem_read_o  = dec_mem_read  & reset_ni;
    assign mem_write_o = dec_mem_write & reset_ni;
    assign alu_src_a_o = dec_src_a;
    assign alu_src_b_o = dec_src_b;
    assign alu_ctrl_o  = dec_alu;
    assign wb_sel_o    = dec_wb;
    assign illegal_o   = dec_illegal;

endmodule

// File: tb/tb_cu_core.sv
// Testbench for cu_core: directed RV32I sequences plus randomized instructions against a reference model.
// Latency: inputs change 1 time unit after a rising edge, outputs are compared 1 unit later.
// Backpressure: not applicable; the DUT takes one instruction per cycle.
module tb_cu_core;

    logic        clk;
    logic        reset_n;
    logic [31:0] instr, rs1_data, rs2_data;
    logic [31:0] pc, pc_plus4, imm;
    logic        reg_write, mem_read, mem_write, alu_src_a, alu_src_b, illegal;
    logic [3:0]  alu_ctrl;
    logic [1:0]  wb_sel;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] mpc;

    localparam logic [31:0] ALU_BASE = {4'd9, 4'd8, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd0};
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] npc;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [1:0]  wb;
        logic        rw, mr, mw, sa, sb, ill;
    } exp_t;

    cu_core dut (
        .clk_i       (clk),
        .reset_ni    (reset_n),
        .instr_i     (instr),
        .rs1_data_i  (rs1_data),
        .rs2_data_i  (rs2_data),
        .pc_o        (pc),
        .pc_plus4_o  (pc_plus4),
        .imm_o       (imm),
        .reg_write_o (reg_write),
        .mem_read_o  (mem_read),
        .mem_write_o (mem_write),
        .alu_src_a_o (alu_src_a),
        .alu_src_b_o (alu_src_b),
        .alu_ctrl_o  (alu_ctrl),
        .wb_sel_o    (wb_sel),
        .illegal_o   (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (model pc %h, instr %h)", tag, obs, exp, mpc, instr);
    endtask

    // Reference behaviour written from the ISA rules, not from the RTL structure
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] cur_pc);
        exp_t        e;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] i_imm, s_imm, b_imm, j_imm, tab;
        logic        take;
        e     = '0;
        op    = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        tab   = ALU_BASE;
        i_imm = $signed(ins) >>> 20;
        s_imm = {i_imm[31:5], ins[11:7]};
        b_imm = s_imm;
        b_imm[11] = ins[7];
        b_imm[0]  = 1'b0;
        j_imm = {i_imm[31:20], ins[19:12], ins[20], ins[30:21], 1'b0};
        e.npc = cur_pc + 32'd4;
        case (f3)
            3'd0: take = (a == b);
            3'd1: take = (a != b);
            3'd4: take = ($signed(a) <  $signed(b));
            3'd5: take = ($signed(a) >= $signed(b));
            3'd6: take = (a <  b);
            3'd7: take = (a >= b);
            default: take = 1'b0;
        endcase
        case (op)
            7'h33: begin
                e.ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
                e.rw  = 1;
                e.alu = tab[f3*4 +: 4] + {3'b0, f7 == 7'h20};
            end
            7'h13: begin
                e.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 == 0 || f7 == 7'h20));
                e.rw  = 1; e.sb = 1; e.imm = i_imm;
                e.alu = tab[f3*4 +: 4] + {3'b0, f3 == 5 && f7 == 7'h20};
            end
            7'h03: begin
                e.ill = (f3 != 2);
                e.rw = 1; e.mr = 1; e.sb = 1; e.wb = 2'd1; e.imm = i_imm;
            end
            7'h23: begin
                e.ill = (f3 != 2);
                e.mw = 1; e.sb = 1; e.imm = s_imm;
            end
            7'h63: begin
                e.ill = (f3 == 2 || f3 == 3);
                e.alu = 4'd1; e.imm = b_imm;
                if (!e.ill && take) e.npc = cur_pc + b_imm;
            end
            7'h6F: begin
                e.rw = 1; e.wb = 2'd2; e.imm = j_imm;
                e.npc = cur_pc + j_imm;
            end
            7'h67: begin
                e.ill = (f3 != 0);
                e.rw = 1; e.wb = 2'd2; e.imm = i_imm;
                if (!e.ill) e.npc = (a + i_imm) & 32'hFFFF_FFFE;
            end
            7'h37: begin
                e.rw = 1; e.sb = 1; e.alu = 4'd10; e.imm = {ins[31:12], 12'h000};
            end
            7'h17: begin
                e.rw = 1; e.sa = 1; e.sb = 1; e.imm = {ins[31:12], 12'h000};
            end
            default: e.ill = 1;
        endcase
        if (e.ill) begin
            e.rw = 0; e.mr = 0; e.mw = 0;
        end
        return e;
    endfunction

    // Apply one instruction, compare decode against the model, then clock it
    task automatic step(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        instr = ins; rs1_data = a; rs2_data = b;
        #1;
        e = model(ins, a, b, mpc);
        chk("pc", pc, mpc);
        chk("pc_plus4", pc_plus4, mpc + 32'd4);
        chk("illegal", {31'b0, illegal}, {31'b0, e.ill});
        chk("reg_write", {31'b0, reg_write}, {31'b0, e.rw});
        chk("mem_read", {31'b0, mem_read}, {31'b0, e.mr});
        chk("mem_write", {31'b0, mem_write}, {31'b0, e.mw});
        if (!e.ill) begin
            chk("imm", imm, e.imm);
            chk("alu_src_a", {31'b0, alu_src_a}, {31'b0, e.sa});
            chk("alu_src_b", {31'b0, alu_src_b}, {31'b0, e.sb});
            chk("alu_ctrl", {28'b0, alu_ctrl}, {28'b0, e.alu});
            chk("wb_sel", {30'b0, wb_sel}, {30'b0, e.wb});
        end
        @(posedge clk);
        mpc = e.npc;
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [10];
        int          k;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
        r = $urandom;
        k = $urandom_range(0, 9);
        r[6:0] = (k == 9) ? 7'($urandom) : ops[k];
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            default: ;
        endcase
        if ((k == 2 || k == 3) && $urandom_range(0, 1) == 1) r[14:12] = 3'b010;
        if (k == 6 && $urandom_range(0, 1) == 1) r[14:12] = 3'b000;
        return r;
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 4))
            0: return 32'hFFFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] a, b;
        reset_n = 1'b0; instr = NOP; rs1_data = 0; rs2_data = 0;
        mpc = 32'h0;
        #2;
        chk("reset_pc", pc, 32'h0);
        chk("reset_pc_plus4", pc_plus4, 32'h4);
        chk("reset_reg_write", {31'b0, reg_write}, 32'h0);
        #10;                         // one rising edge passes while reset is held
        chk("reset_hold_pc", pc, 32'h0);
        reset_n = 1'b1;              // released between edges
        #1;

        // addi x0,x0,0 sequence: 0, 4, 8, 12, 16
        for (int i = 0; i < 4; i++) step(NOP, 32'h0, 32'h0);
        chk("addi_alu_ctrl", {28'b0, alu_ctrl}, 32'h0);
        chk("addi_imm", imm, 32'h0);
        chk("pc_after_addi", pc, 32'h10);

        step(32'h0020_8463, 32'd5, 32'd5);         // beq taken
        chk("beq_taken_pc", pc, 32'h18);
        step(32'h0020_8463, 32'd5, 32'd6);         // beq not taken
        chk("beq_not_taken_pc", pc, 32'h1C);
        step(32'h0020_C463, 32'hFFFF_FFFF, 32'd1); // blt taken
        chk("blt_taken_pc", pc, 32'h24);
        step(32'h0020_E463, 32'hFFFF_FFFF, 32'd1); // bltu not taken
        chk("bltu_not_taken_pc", pc, 32'h28);
        step(32'h0000_80E7, 32'h103, 32'h0);       // jalr x1,0(x1)
        chk("jalr_pc", pc, 32'h102);
        instr = 32'h0040_A183; #1;
        chk("lw_imm", imm, 32'h4);
        step(32'h0040_A183, 32'h0, 32'h0);
        instr = 32'h0030_A223; #1;
        chk("sw_imm", imm, 32'h4);
        step(32'h0030_A223, 32'h0, 32'h0);
        step(32'hFFFF_FFFF, 32'h0, 32'h0);         // illegal falls through
        chk("illegal_pc", pc, 32'h10E);

        for (int i = 0; i < 400; i++) begin
            a = rand_val();
            b = ($urandom_range(0, 3) == 0) ? a : rand_val();
            step(rand_instr(), a, b);
        end

        // Asynchronous reset mid-cycle with a load in flight
        instr = 32'h0040_A183;
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset_pc", pc, 32'h0);
        chk("midreset_mem_read", {31'b0, mem_read}, 32'h0);
        chk("midreset_reg_write", {31'b0, reg_write}, 32'h0);
        @(posedge clk); #1;
        chk("midreset_hold_pc", pc, 32'h0);
        reset_n = 1'b1;
        mpc = 32'h0;
        for (int i = 0; i < 3; i++) step(NOP, 32'h0, 32'h0);
        chk("post_reset_pc", pc, 32'hC);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
